// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch initiator.
// Drives a word-aligned fetch PC into a combinational instruction memory,
// buffers {pc, inst} pairs in a small FIFO, presents the head to decode over
// a valid/ready handshake, and flushes/restarts on a redirect from execute.
module ifetch_unit #(
    parameter int                IMEM_W     = 32,
    parameter logic [IMEM_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,          // synchronous, active-high
    output logic [IMEM_W-1:0] paddr_o,
    input  logic [31:0]       prdata_i,
    input  logic              redirect_i,
    input  logic [IMEM_W-1:0] redirect_pc_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [31:0]       inst_o,
    output logic [IMEM_W-1:0] inst_pc_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PONE_C  = PTR_W'(1);
    localparam logic [IMEM_W-1:0] STEP_C  = IMEM_W'(4);

    // Architectural state
    logic [IMEM_W-1:0] fetch_pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    // Instruction buffer storage
    logic [IMEM_W-1:0] pc_mem   [FIFO_DEPTH];
    logic [31:0]       inst_mem [FIFO_DEPTH];

    // Handshake and fill decisions for this cycle
    logic pop;
    logic push;
    logic [IMEM_W-1:0] redirect_target;

    assign pop  = inst_valid_o & inst_ready_i;
    // A pop frees a slot in the same cycle, so a full buffer refills with no bubble.
    assign push = ~redirect_i & ((count < DEPTH_C) | pop);

    // The low two bits of a redirect target are ignored; fetch is word aligned.
    assign redirect_target = {redirect_pc_i[IMEM_W-1:2], 2'b00};

    assign paddr_o = fetch_pc;

    // Control state: reset first, then redirect flush, then normal push/pop.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst_ni) begin
            fetch_pc <= {RESET_PC[IMEM_W-1:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            // A pop completing this cycle is discarded along with the rest.
            fetch_pc <= redirect_target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + STEP_C;
                wr_ptr   <= wr_ptr + PONE_C;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PONE_C;
            end
            if (push && !pop) begin
                count <= count + ONE_C;
            end else if (pop && !push) begin
                count <= count - ONE_C;
            end
        end
    end

    // Buffer write port: captures the PC and the word the memory returned for it.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; the count gates the outputs,
        // so stale contents are never visible and no reset fanout is needed.
        if (!rst_ni && push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= prdata_i;
        end
    end

    // Head presentation: registers only, forced to zero while empty.
    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : 32'h0;
    assign inst_pc_o    = inst_valid_o ? pc_mem[rd_ptr]   : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and randomized checks of ifetch_unit against a
// queue-based reference model of the fetch buffer.
module tb_ifetch_unit;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic [31:0] paddr;
    logic [31:0] prdata;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    // Small-address-space instance for the wrap test
    logic        sm_rst;
    logic [7:0]  sm_paddr;
    logic [31:0] sm_prdata;
    logic        sm_valid;
    logic [31:0] sm_inst;
    logic [7:0]  sm_inst_pc;

    int checks = 0;
    int errors = 0;

    // Reference model state
    entry_t      q[$];
    logic [31:0] mpc;

    // Head-stability tracking
    logic        hold;
    logic [31:0] held_inst;
    logic [31:0] held_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    always_comb prdata    = mem_word(paddr);
    always_comb sm_prdata = 32'hB000_0000 | {24'h0, sm_paddr};

    ifetch_unit #(.IMEM_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst),
        .paddr_o      (paddr),
        .prdata_i     (prdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .inst_valid_o (valid),
        .inst_ready_i (ready),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc)
    );

    ifetch_unit #(.IMEM_W(8), .RESET_PC(8'hF8), .FIFO_DEPTH(DEPTH)) dut_small (
        .clk_i        (clk),
        .rst_ni       (sm_rst),
        .paddr_o      (sm_paddr),
        .prdata_i     (sm_prdata),
        .redirect_i   (1'b0),
        .redirect_pc_i(8'h00),
        .inst_valid_o (sm_valid),
        .inst_ready_i (1'b1),
        .inst_o       (sm_inst),
        .inst_pc_o    (sm_inst_pc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all DUT outputs against the model (called away from the clock edge).
    task automatic compare();
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        ev = (q.size() != 0);
        ei = ev ? q[0].inst : 32'h0;
        ep = ev ? q[0].pc   : 32'h0;
        check("valid", 64'(valid), 64'(ev));
        check("inst", 64'(inst), 64'(ei));
        check("inst_pc", 64'(inst_pc), 64'(ep));
        check("paddr", 64'(paddr), 64'(mpc));
        if (hold) begin
            check("hold_inst", 64'(inst), 64'(held_inst));
            check("hold_pc", 64'(inst_pc), 64'(held_pc));
        end
    endtask

    // One clock: check outputs, drive inputs, advance DUT and model together.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        logic popped;
        logic full;
        compare();
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        ready       = rdy;
        hold        = valid && !rdy && !rd && !r;
        held_inst   = inst;
        held_pc     = inst_pc;
        @(posedge clk);
        if (r) begin
            q.delete();
            mpc = 32'h0;
        end else if (rd) begin
            q.delete();
            mpc = rpc & ~32'h3;
        end else begin
            popped = (q.size() != 0) && rdy;
            full   = (q.size() == DEPTH);
            if (popped) void'(q.pop_front());
            if (!full || popped) begin
                q.push_back('{pc: mpc, inst: mem_word(mpc)});
                mpc = mpc + 32'h4;
            end
        end
        @(negedge clk);
    endtask

    logic [7:0] wrap_pcs [4];

    initial begin
        rst         = 1'b1;
        sm_rst      = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ready       = 1'b0;
        hold        = 1'b0;
        held_inst   = 32'h0;
        held_pc     = 32'h0;
        mpc         = 32'h0;
        q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_valid", 64'(valid), 64'(1'b0));
        check("rst_inst", 64'(inst), 64'h0);
        check("rst_pc", 64'(inst_pc), 64'h0);
        check("rst_paddr", 64'(paddr), 64'h0);

        // Free run with ready=1
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("run_pc", 64'(inst_pc), 64'h1C);
        check("run_inst", 64'(inst), 64'hA000_0007);

        // Stall: reset, then ready=0 for 10 cycles, then drain
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_paddr", 64'(paddr), 64'h10);
        check("stall_valid", 64'(valid), 64'(1'b1));
        check("stall_head", 64'(inst_pc), 64'h0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_pc", 64'(inst_pc), 64'h20);

        // Redirect with 3 entries buffered
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("pre_redir_head", 64'(inst_pc), 64'h0);
        step(1'b0, 1'b1, 32'h103, 1'b1);
        check("redir_valid", 64'(valid), 64'(1'b0));
        check("redir_paddr", 64'(paddr), 64'h100);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_first_valid", 64'(valid), 64'(1'b1));
        check("redir_first_pc", 64'(inst_pc), 64'h100);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Back-to-back redirects: only the last one fetches
        step(1'b0, 1'b1, 32'h400, 1'b1);
        step(1'b0, 1'b1, 32'h802, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("b2b_pc", 64'(inst_pc), 64'h800);

        // Redirect and reset together
        step(1'b1, 1'b1, 32'h200, 1'b1);
        check("rr_paddr", 64'(paddr), 64'h0);
        check("rr_valid", 64'(valid), 64'(1'b0));
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random stress
        for (int k = 0; k < 3000; k++) begin
            logic r;
            logic rd;
            logic rdy;
            r   = ($urandom_range(0, 199) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            step(r, rd, $urandom, rdy);
        end
        compare();

        // PC wrap on the 8-bit instance
        wrap_pcs[0] = 8'hF8;
        wrap_pcs[1] = 8'hFC;
        wrap_pcs[2] = 8'h00;
        wrap_pcs[3] = 8'h04;
        @(negedge clk);
        sm_rst = 1'b0;
        check("sm_rst_valid", 64'(sm_valid), 64'(1'b0));
        check("sm_rst_paddr", 64'(sm_paddr), 64'hF8);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("sm_valid", 64'(sm_valid), 64'(1'b1));
            check("sm_pc", 64'(sm_inst_pc), 64'(wrap_pcs[k]));
            check("sm_inst", 64'(sm_inst), 64'(32'hB000_0000 | {24'h0, wrap_pcs[k]}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
